apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- APB requester-side controller. Arbitrates round-robin between NREQ local requesters and drives one APB completer through the standard IDLE/SETUP/ACCESS sequence.
- Each requester issues one transfer through a valid/ready request handshake. The completion comes back as a one-cycle response pulse carrying read data and an error flag.
- A watchdog aborts any ACCESS phase that exceeds TIMEOUT wait cycles, so a hung completer cannot lock out the bus.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort. 0 disables the watchdog.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester transfer request.
- req_ready  out  NREQ  one-hot accept. Transfer accepted on the edge where req_valid[i]&req_ready[i].
- req_write  in  NREQ  1=write, 0=read, per requester.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; same packing as req_addr.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DW  read data; valid while any rsp_valid bit is high.
- rsp_err  out  1  PSLVERR or timeout, qualified by rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  AW  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB completer error.

Behaviour:
- Reset (async, PRESETn=0):
  - State=IDLE.
  - All registered outputs are 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err.
  - last_grant=NREQ-1, so requester 0 wins first.
  - wait_cnt=0.
  - An in-flight transfer is dropped with no response.
- req_ready is combinational and nonzero only in IDLE. It is one-hot for the first requester with req_valid set, searching upward from (last_grant+1) mod NREQ with wrap. It is all-zero in SETUP and ACCESS.
- IDLE:
  - On acceptance, register grant index g, PADDR, PWRITE and PWDATA (PWDATA is captured for reads as well).
  - Set PSEL=1, last_grant=g, and go to SETUP.
  - PADDR, PWRITE and PWDATA otherwise hold their last values.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0. Next state is ACCESS with PENABLE=1 and wait_cnt=0.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA are stable.
  - PREADY sampled 1: drive rsp_valid[g]=1 next cycle, rsp_rdata=PRDATA on reads (0 on writes), rsp_err=PSLVERR. Clear PSEL and PENABLE, go to IDLE.
  - PREADY=0 and TIMEOUT!=0: wait_cnt increments. When wait_cnt reaches TIMEOUT-1 and PREADY is still 0, abort: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, PSEL and PENABLE cleared, go to IDLE.
  - PREADY=1 on the timeout cycle counts as a normal completion, not an abort.
- rsp_valid lasts exactly one cycle.
- Back-to-back transfers:
  - The IDLE cycle that carries the response can also accept the next request.
  - Minimum transfer is 3 cycles (IDLE accept, SETUP, ACCESS with PREADY=1).
- Fairness: a requester holding req_valid waits at most NREQ-1 other transfers.
- req_valid deasserted before acceptance is allowed; the request is simply not granted.
- Timing: no combinational path from APB inputs to any output. req_ready depends only on req_valid, state and last_grant.
- Width: wait_cnt is $clog2(TIMEOUT+1) bits and saturates. It is never compared when TIMEOUT==0.

Decomposition:
- Shared package apb_pkg:
  - typedef enum apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - localparams APB_AW=32 and APB_DW=32, reused by the existing completer.
- Sub-module rr_arbiter (param NREQ):
  - Inputs: req, last_grant.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; instantiated once.

Test Plan:
- Single write: requester 0 writes 0xDEADBEEF to 0x10; completer raises PREADY in the second ACCESS cycle -> PSEL high 3 cycles, PENABLE high 2, PWDATA=0xDEADBEEF throughout, one rsp_valid[0] pulse, rsp_err=0.
- Readback: requester 1 reads 0x10 -> rsp_valid[1] pulse, rsp_rdata=0xDEADBEEF, rsp_err=0; PADDR=0x10 stable from SETUP to completion.
- Contention: both req_valid held for 4 transfers from reset -> grant order 0,1,0,1, each with one matching rsp_valid pulse, and the IDLE gap between transfers is 1 cycle.
- Error: completer returns PSLVERR=1 with PREADY=1 -> rsp_err=1 on the matching rsp_valid, and the next request is accepted normally.
- Timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0 next cycle. With PREADY=1 on the 4th cycle -> normal completion instead.
- Reset mid-ACCESS: drop PRESETn during ACCESS -> PSEL, PENABLE and rsp_valid go 0 immediately with no clock; after release, requester 0 has priority and no stale response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: APB phase encoding and default bus widths shared by requester and completer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching upward from last_grant+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used this cycle.
// Ports: req (request vector), last_grant (index of previous winner),
//        grant (one-hot winner), grant_idx (winner index), any_grant (some request won).
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_grant
);

  // Distance k = 1 is the highest-priority slot (just after the last winner),
  // k = NREQ is the last winner itself. The inner loop keeps every bit index
  // constant; the second equality term handles the wrap past NREQ-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_grant && req[i] &&
            ((int'(last_grant) + k == i) || (int'(last_grant) + k - NREQ == i))) begin
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin arbiter over NREQ requesters driving one APB completer.
// Latency: 3 cycles minimum from accept to response pulse (IDLE, SETUP, ACCESS with PREADY).
// Backpressure: req_ready only in IDLE; a stalled completer is aborted after TIMEOUT wait cycles.
// Ports: req_* (per-requester valid/ready request, packed addr/wdata), rsp_* (one-cycle
//        completion pulse with rdata/err), P* (APB requester-side bus). PCLK / PRESETn async low.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [AW-1:0]     PADDR,
  output logic              PWRITE,
  output logic [DW-1:0]     PWDATA,
  input  logic [DW-1:0]     PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int IW = $clog2(NREQ);
  // Counter keeps at least one bit so a disabled watchdog still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] W_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e      r_state;
  logic [IW-1:0]   r_last;
  logic [NREQ-1:0] r_gnt_oh;
  logic [CW-1:0]   r_wait_cnt;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_grant_idx;
  logic            w_any;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_write;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .last_grant (r_last),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any_grant  (w_any)
  );

  // Only IDLE offers a grant; APB inputs never reach req_ready.
  assign req_ready = (r_state == APB_IDLE) ? w_grant : '0;

  // Mux the winner's request fields using the one-hot grant.
  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_write = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_addr  = req_addr[i*AW +: AW];
        w_wdata = req_wdata[i*DW +: DW];
        w_write = req_write[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= APB_IDLE;
      r_last     <= IW'(NREQ - 1);
      r_gnt_oh   <= '0;
      r_wait_cnt <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (r_state)
        APB_IDLE: begin
          if (w_any) begin
            r_gnt_oh <= w_grant;
            r_last   <= w_grant_idx;
            PADDR    <= w_addr;
            PWRITE   <= w_write;
            PWDATA   <= w_wdata;
            PSEL     <= 1'b1;
            r_state  <= APB_SETUP;
          end
        end
        APB_SETUP: begin
          PENABLE    <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= APB_ACCESS;
        end
        APB_ACCESS: begin
          // PREADY wins over the watchdog on the final wait cycle.
          if (PREADY) begin
            rsp_valid <= r_gnt_oh;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= APB_IDLE;
          end else if (TIMEOUT != 0) begin
            if (r_wait_cnt == W_LAST) begin
              rsp_valid <= r_gnt_oh;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              PSEL      <= 1'b0;
              PENABLE   <= 1'b0;
              r_state   <= APB_IDLE;
            end else if (r_wait_cnt != '1) begin
              r_wait_cnt <= r_wait_cnt + CW'(1);
            end
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          r_state <= APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: randomized and directed stimulus, scoreboard-checked responses.
// Latency: n/a (bench).
// Backpressure: bench completer inserts programmable wait states per transfer.
module tb_apb_master_arbiter;

  localparam int N  = 3;
  localparam int TO = 4;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]     rsp_rdata, PADDR, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  apb_master_arbiter #(.NREQ(N), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          pcyc;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: expected memory image, round-robin pointer, bus occupancy.
  logic [31:0] exp_mem [8];
  logic [31:0] dev_mem [8];
  logic [N-1:0] nv = '0;
  logic         nv_wr   [N];
  logic [31:0]  nv_addr [N];
  logic [31:0]  nv_wd   [N];
  logic [N-1:0] hold_mask = '0;
  bit           rand_en = 1'b0;
  int last_g = N - 1;
  int busy_cnt = 0;
  int acc_idx = -1;
  int xfers = 0;
  int force_wait = -1;
  int force_err = -1;
  int cur_wait = 0;
  logic cur_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom() & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  // Winner = first valid requester at distance 1..N after the previous winner.
  function automatic int pick(input logic [N-1:0] m, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  task automatic new_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic set_nv(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    nv[i] = 1'b1; nv_wr[i] = wr; nv_addr[i] = a; nv_wd[i] = d;
  endtask

  task automatic accept(input int w);
    int wt, n;
    logic er;
    exp_t e;
    wt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 5));
    er = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 5) == 0);
    n = (wt < TO) ? wt + 1 : TO;
    e.idx = w; e.wr = req_write[w];
    e.addr = req_addr[w*32 +: 32]; e.wdata = req_wdata[w*32 +: 32];
    e.pcyc = n + 1;
    if (wt >= TO) begin
      e.err = 1'b1; e.rdata = '0;
    end else begin
      e.err = er;
      e.rdata = e.wr ? 32'h0 : exp_mem[e.addr[4:2]];
      if (e.wr && !er) exp_mem[e.addr[4:2]] = e.wdata;
    end
    sb.push_back(e);
    cur_wait = wt; cur_err = er;
    last_g = w; acc_idx = w; busy_cnt = n + 2; xfers++;
  endtask

  task automatic step_body();
    logic [N-1:0] want_rdy;
    int w;
    if (acc_idx >= 0) begin req_valid[acc_idx] = 1'b0; acc_idx = -1; end
    if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) begin
        if (nv[i]) begin
          new_req(i, nv_wr[i], nv_addr[i], nv_wd[i]); nv[i] = 1'b0;
        end else if (hold_mask[i] || (rand_en && $urandom_range(0, 2) == 0)) begin
          new_req(i, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
        end
      end else if (rand_en && $urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    #1;
    want_rdy = '0; w = -1;
    if (busy_cnt == 0) begin
      w = pick(req_valid, last_g);
      if (w >= 0) want_rdy[w] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(want_rdy));
    if (w >= 0) accept(w);
  endtask

  task automatic step();
    @(negedge PCLK);
    step_body();
  endtask

  task automatic drain(input int max, input string tag);
    int c;
    c = 0;
    do begin step(); c++; end
    while (c < max && !(req_valid == '0 && nv == '0 && busy_cnt == 0 && sb.size() == 0));
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    chk({tag, "_no_pending"}, 64'(req_valid), 64'(0));
  endtask

  // Asserted between edges so the async clear is observed with no clock.
  task automatic apply_reset(input string tag);
    #2 PRESETn = 1'b0;
    #1;
    chk({tag, "_psel"}, 64'(PSEL), 64'(0));
    chk({tag, "_penable"}, 64'(PENABLE), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    sb.delete(); busy_cnt = 0; last_g = N - 1; acc_idx = -1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    step_body();
  endtask

  // Completer: PREADY on ACCESS cycle cur_wait+1; garbage on PRDATA/PSLVERR otherwise.
  initial begin
    int acnt;
    acnt = 0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (PRESETn && PSEL && PENABLE) acnt++; else acnt = 0;
      PREADY  = (acnt != 0) && (acnt == cur_wait + 1);
      PSLVERR = PREADY ? cur_err : 1'($urandom_range(0, 1));
      if (PREADY && !PWRITE) PRDATA = dev_mem[PADDR[4:2]];
      else PRDATA = $urandom();
      if (PREADY && PWRITE && !cur_err) dev_mem[PADDR[4:2]] = PWDATA;
    end
  end

  // Monitor: tracks each PSEL window and pops the scoreboard on every response pulse.
  initial begin
    int run, last_run;
    logic setup_pen, cap_wr, unstable;
    logic [31:0] cap_addr, cap_wd;
    logic [N-1:0] oh;
    exp_t e;
    run = 0; last_run = 0; setup_pen = 1'b0; cap_wr = 1'b0; unstable = 1'b0;
    cap_addr = '0; cap_wd = '0;
    forever begin
      @(negedge PCLK);
      if (PRESETn !== 1'b1) begin run = 0; continue; end
      if (PSEL) begin
        run++;
        if (run == 1) begin
          setup_pen = PENABLE; cap_addr = PADDR; cap_wr = PWRITE; cap_wd = PWDATA; unstable = 1'b0;
        end else if (PADDR !== cap_addr || PWRITE !== cap_wr || PWDATA !== cap_wd || !PENABLE) begin
          unstable = 1'b1;
        end
      end else if (run > 0) begin
        last_run = run; run = 0;
      end
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          chk("stale_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          chk("rsp_valid", 64'(rsp_valid), 64'(oh));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("psel_cycles", 64'(last_run), 64'(e.pcyc));
          chk("setup_penable", 64'(setup_pen), 64'(0));
          chk("paddr", 64'(cap_addr), 64'(e.addr));
          chk("pwrite", 64'(cap_wr), 64'(e.wr));
          chk("pwdata", 64'(cap_wd), 64'(e.wdata));
          chk("bus_stable", 64'(unstable), 64'(0));
          chk("rsp_penable", 64'(PENABLE), 64'(0));
        end
        last_run = 0;
      end
    end
  end

  initial begin
    logic [31:0] v;
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 8; k++) begin
      v = $urandom(); exp_mem[k] = v; dev_mem[k] = v;
    end
    repeat (3) @(negedge PCLK);
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    PRESETn = 1'b1;
    step_body();

    // Single write, PREADY in second ACCESS cycle; then readback by requester 1.
    force_wait = 1; force_err = 0;
    set_nv(0, 1'b1, 32'h10, 32'hDEADBEEF);
    drain(40, "write");
    force_wait = 0;
    set_nv(1, 1'b0, 32'h10, $urandom());
    drain(40, "readback");

    // Contention from reset: requesters 0 and 1 hold valid continuously.
    apply_reset("rst_idle");
    hold_mask = 3'b011;
    begin
      int target, c;
      target = xfers + 4; c = 0;
      while (xfers < target && c < 60) begin step(); c++; end
    end
    hold_mask = '0;
    drain(60, "contention");

    // Completer error on write and on read, then a normal transfer.
    force_err = 1;
    set_nv(2, 1'b1, 32'h20, $urandom());
    drain(40, "err_wr");
    set_nv(1, 1'b0, 32'h14, $urandom());
    drain(40, "err_rd");
    force_err = 0;
    set_nv(0, 1'b0, 32'h20, $urandom());
    drain(40, "after_err");

    // Watchdog abort, then PREADY exactly on the final allowed cycle.
    force_wait = 20;
    set_nv(0, 1'b0, 32'h18, $urandom());
    drain(40, "timeout");
    force_wait = 3;
    set_nv(1, 1'b0, 32'h18, $urandom());
    drain(40, "last_cycle_rd");
    set_nv(2, 1'b1, 32'h18, $urandom());
    drain(40, "last_cycle_wr");

    // Reset while requester 1 sits in ACCESS; requesters 0 and 2 queued behind it.
    force_wait = 20;
    set_nv(1, 1'b1, 32'h1C, $urandom());
    begin
      int target, c;
      target = xfers + 1; c = 0;
      while (xfers < target && c < 20) begin step(); c++; end
    end
    set_nv(0, 1'b0, 32'h1C, $urandom());
    set_nv(2, 1'b0, 32'h10, $urandom());
    repeat (3) step();
    force_wait = 0;
    apply_reset("rst_access");
    drain(40, "post_reset");

    // Randomized traffic.
    force_wait = -1; force_err = -1;
    rand_en = 1'b1;
    repeat (1500) step();
    rand_en = 1'b0;
    drain(300, "random");

    repeat (5) step();
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
